huff_merge_ctrl: RTL and testbench
==================================

Name: huff_merge_ctrl

Overview:
- Initiator side of the sorter's update interface. The sorter is the existing 6-entry ascending sort with one-hot symbol flags.
- After each sort completes, this block takes the two smallest entries and writes back their merged entry (sum of counts, OR of flags) through `update_*`. It decrements `num` and repeats until one entry remains.
- While merging, it builds a per-symbol Huffman code and code length. Sits between the frequency counter/sorter and the bitstream encoder.

Parameters:
- DATA_W, 8: width of one count entry. Must match the sorter's data length.
- FLAG_W, 6: number of symbols, which equals the flag width and the entry count.
- CODE_W, 5: per-symbol code register width. Must be at least FLAG_W-1.
- LEN_W, 3: per-symbol length width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; issued in the same cycle the sorter is `set`
- sym_num  in  3  number of valid symbols, 0..6; sampled on start
- sorted_data  in  FLAG_W*DATA_W  sorter output; entry 0 is the MSB slice; ascending order
- sorted_flag  in  FLAG_W*FLAG_W  sorter flags, same packing
- sort_done  in  1  sorter done level
- num  out  3  valid entry count driven to the sorter
- update_data  out  DATA_W  merged count
- update_flag  out  FLAG_W  merged flag set
- update_en  out  1  one-cycle update strobe
- code  out  FLAG_W*CODE_W  codes; symbol 0 is the MSB slice; LSB-aligned
- code_len  out  FLAG_W*LEN_W  code lengths, same packing
- busy  out  1  high from the cycle after start until done
- done  out  1  high while in DONE
- err  out  1  sym_num<2 or sym_num>FLAG_W

Behaviour:
- **Reset values:** every output is 0 and the state is IDLE. Reset mid-run aborts immediately; update_en is 0 in the following cycle.
- **Bit/symbol mapping:** flag bit i is symbol i. Entries 0..num-1 are valid. Entries at or above num are ignored.
- **State IDLE**
  - On start: latch sym_num into num, clear all code and code_len, clear err.
  - If sym_num<2 or sym_num>FLAG_W: set err=1 and go to DONE.
  - Otherwise go to WAIT_SORT.
  - start in any other state is ignored.
- **State WAIT_SORT:** wait for sort_done=1, then go to MERGE.
- **State MERGE (1 cycle)**
  - Let d0,f0 be entry 0 and d1,f1 be entry 1.
  - For every i with f0[i]=1: code_i[len_i]=0 and len_i+1.
  - For every i with f1[i]=1: code_i[len_i]=1 and len_i+1.
  - Bits are prepended, so the last merge ends up as the code MSB.
  - Ties need no special handling: entry 0 always gets bit 0.
  - Register update_data=d0+d1 and update_flag=f0|f1.
  - Set num=num-1, then go to UPDATE.
- **State UPDATE (1 cycle):** update_en=1 with the registered num. Then:
  - If num==1, go to DONE.
  - Otherwise go to WAIT_LOW.
- **State WAIT_LOW:** wait for sort_done=0, so a stale done from the previous pass is never reused. Then go to WAIT_SORT.
- **State DONE:** done=1, busy=0. code, code_len and num hold. A start pulse begins a new run, exactly as from IDLE.
- **Pass count:** exactly sym_num-1 update_en pulses per run. Latency per pass is sorter time plus 2 cycles (MERGE + UPDATE).
- **Invariants:**
  - update_en is never high for two consecutive cycles.
  - update_data and update_flag are stable while update_en=1.
  - num never goes below 1.
- **Flag checks:** if f0&f1 is nonzero, or either flag is zero, set err=1, go to DONE, and stop issuing updates.

Optional Feature:
- **HUFF_SUM_SAT_EN defined:** d0+d1 saturates to all-ones when the carry out of DATA_W is set.
- **Undefined:** the sum wraps modulo 2^DATA_W.
- In both builds the code and length generation is unaffected.

Test Plan:
- **Full 6-symbol run:** counts sym0..5 = 1,5,6,2,3,4, one-hot flags, behavioural sorter (a merged entry sorts after equal counts).
  - Required: 5 update_en pulses with (update_data, update_flag) = (3,001001), (6,011001), (9,100010), (12,011101), (21,111111).
  - Required: num sequence 5,4,3,2,1.
  - Required: codes/lengths sym0 1110/4, sym1 01/2, sym2 10/2, sym3 1111/4, sym4 110/3, sym5 00/2. done=1, err=0.
- **Two-symbol run:** sym_num=2, counts 7 and 9.
  - Required: one update (16,000011), num=1.
  - Required: code 0 with len 1 for the lower-count symbol, code 1 with len 1 for the other.
- **Invalid count:** sym_num=1 -> err=1, done=1 the cycle after start, no update_en. Repeat with sym_num=7 -> same result.
- **Stale done:** hold sort_done=1 continuously after the first pass.
  - Required: the controller stays in WAIT_LOW and issues no second update until sort_done has dropped and risen again.
- **Reset mid-run:** assert reset during the third pass.
  - Required: next cycle all outputs are 0 and the state is IDLE.
  - Then a fresh start with the first-scenario data reproduces the first-scenario results.
- **Sum overflow:** DATA_W=8, counts 200 and 100.
  - With HUFF_SUM_SAT_EN: update_data=255.
  - Without it: update_data=44.

Source files
------------

// File: rtl/huff_merge_ctrl.sv
// Huffman merge controller: drives the sorter's update port, merging the two smallest
// entries each pass and building per-symbol codes. Define HUFF_SUM_SAT_EN to saturate merged counts.
module huff_merge_ctrl #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 6,
  parameter int CODE_W = 5,
  parameter int LEN_W  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 sym_num,
  input  logic [FLAG_W*DATA_W-1:0]   sorted_data,
  input  logic [FLAG_W*FLAG_W-1:0]   sorted_flag,
  input  logic                       sort_done,
  output logic [2:0]                 num,
  output logic [DATA_W-1:0]          update_data,
  output logic [FLAG_W-1:0]          update_flag,
  output logic                       update_en,
  output logic [FLAG_W*CODE_W-1:0]   code,
  output logic [FLAG_W*LEN_W-1:0]    code_len,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_SORT, ST_MERGE, ST_UPDATE, ST_WAIT_LOW, ST_DONE
  } state_t;

  localparam logic [2:0] MAX_SYM = 3'(FLAG_W);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   d0, d1, merged_data;
  logic [FLAG_W-1:0]   f0, f1;
  logic                sym_bad, flag_bad;
  logic [CODE_W-1:0]   code_r [FLAG_W];
  logic [LEN_W-1:0]    len_r  [FLAG_W];

  // Entry 0 (the smallest) sits in the MSB slice of the sorter buses.
  assign d0 = sorted_data[FLAG_W*DATA_W-1     -: DATA_W];
  assign d1 = sorted_data[(FLAG_W-1)*DATA_W-1 -: DATA_W];
  assign f0 = sorted_flag[FLAG_W*FLAG_W-1     -: FLAG_W];
  assign f1 = sorted_flag[(FLAG_W-1)*FLAG_W-1 -: FLAG_W];

  assign sym_bad  = (sym_num < 3'd2) || (sym_num > MAX_SYM);
  assign flag_bad = ((f0 & f1) != '0) || (f0 == '0) || (f1 == '0);

`ifdef HUFF_SUM_SAT_EN
  logic [DATA_W:0] sum_ext;
  assign sum_ext     = {1'b0, d0} + {1'b0, d1};
  assign merged_data = sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
`else
  assign merged_data = d0 + d1;
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first, so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = sym_bad ? ST_DONE : ST_WAIT_SORT;
      ST_WAIT_SORT:     if (sort_done) state_nxt = ST_MERGE;
      ST_MERGE:         state_nxt = flag_bad ? ST_DONE : ST_UPDATE;
      ST_UPDATE:        state_nxt = (num == 3'd1) ? ST_DONE : ST_WAIT_LOW;
      ST_WAIT_LOW:      if (!sort_done) state_nxt = ST_WAIT_SORT;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    update_en = (state == ST_UPDATE);
    done      = (state == ST_DONE);
    busy      = (state == ST_WAIT_SORT) || (state == ST_MERGE) ||
                (state == ST_UPDATE)    || (state == ST_WAIT_LOW);
  end

  // NOTE: code/len arrays are small flop banks, not RAM, so resetting them is fine.
  always_ff @(posedge clk) begin
    if (reset) begin
      num         <= '0;
      update_data <= '0;
      update_flag <= '0;
      err         <= 1'b0;
      for (int i = 0; i < FLAG_W; i++) begin
        code_r[i] <= '0;
        len_r[i]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num <= sym_num;
            err <= sym_bad;
            for (int i = 0; i < FLAG_W; i++) begin
              code_r[i] <= '0;
              len_r[i]  <= '0;
            end
          end
        end
        ST_MERGE: begin
          if (flag_bad) begin
            err <= 1'b1;
          end else begin
            update_data <= merged_data;
            update_flag <= f0 | f1;
            num         <= num - 3'd1;
            // Each merge prepends one bit, so the final merge lands at the code MSB.
            for (int i = 0; i < FLAG_W; i++) begin
              if (f0[i]) begin
                code_r[i][len_r[i]] <= 1'b0;
                len_r[i]            <= len_r[i] + 1'b1;
              end else if (f1[i]) begin
                code_r[i][len_r[i]] <= 1'b1;
                len_r[i]            <= len_r[i] + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    code     = '0;
    code_len = '0;
    for (int i = 0; i < FLAG_W; i++) begin
      code[(FLAG_W-i)*CODE_W-1 -: CODE_W]    = code_r[i];
      code_len[(FLAG_W-i)*LEN_W-1 -: LEN_W]  = len_r[i];
    end
  end

endmodule

// File: tb/tb_huff_merge_ctrl.sv
// Bench for huff_merge_ctrl: behavioural sorter peer plus an update scoreboard.
module tb_huff_merge_ctrl;

  localparam int DATA_W   = 8;
  localparam int FLAG_W   = 6;
  localparam int CODE_W   = 5;
  localparam int LEN_W    = 3;
  localparam int SORT_LAT = 3;

  localparam logic [FLAG_W*DATA_W-1:0] CNT6 = {8'd1, 8'd5, 8'd6, 8'd2, 8'd3, 8'd4};
  localparam logic [FLAG_W*CODE_W-1:0] EXP_CODE6 =
    {5'b01110, 5'b00001, 5'b00010, 5'b01111, 5'b00110, 5'b00000};
  localparam logic [FLAG_W*LEN_W-1:0] EXP_LEN6 = {3'd4, 3'd2, 3'd2, 3'd4, 3'd3, 3'd2};
`ifdef HUFF_SUM_SAT_EN
  localparam logic [DATA_W-1:0] OVF_EXP = 8'd255;
`else
  localparam logic [DATA_W-1:0] OVF_EXP = 8'd44;
`endif

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      start = 1'b0;
  logic [2:0]                sym_num = '0;
  logic [FLAG_W*DATA_W-1:0]  sorted_data = '0;
  logic [FLAG_W*FLAG_W-1:0]  sorted_flag = '0;
  logic                      sort_done = 1'b0;
  logic [2:0]                num;
  logic [DATA_W-1:0]         update_data;
  logic [FLAG_W-1:0]         update_flag;
  logic                      update_en;
  logic [FLAG_W*CODE_W-1:0]  code;
  logic [FLAG_W*LEN_W-1:0]   code_len;
  logic                      busy, done, err;

  huff_merge_ctrl #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .sym_num(sym_num),
    .sorted_data(sorted_data), .sorted_flag(sorted_flag), .sort_done(sort_done),
    .num(num), .update_data(update_data), .update_flag(update_flag), .update_en(update_en),
    .code(code), .code_len(code_len), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flag;
    logic [2:0]        num;
  } upd_t;

  upd_t exp_q[$];
  upd_t obs_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   viol     = 0;
  logic prev_en  = 1'b0;
  upd_t mon_u;

  function automatic upd_t mk(input logic [DATA_W-1:0] d, input logic [FLAG_W-1:0] f,
                              input logic [2:0] n);
    upd_t u;
    u.data = d; u.flag = f; u.num = n;
    return u;
  endfunction

  // Monitor: records every update strobe and counts back-to-back strobes.
  always @(negedge clk) begin
    if (update_en) begin
      mon_u = mk(update_data, update_flag, num);
      obs_q.push_back(mon_u);
      if (prev_en) viol++;
    end
    prev_en = update_en;
  end

  // Behavioural sorter: stable ascending order, merged entry after equal counts.
  logic [DATA_W-1:0]        m_cnt  [FLAG_W];
  logic [FLAG_W-1:0]        m_flag [FLAG_W];
  int                       m_n = 0, m_timer = 0;
  int                       ld_n = 0, ld_seq = 0, ld_seen = 0, drop_seq = 0, drop_seen = 0;
  logic [FLAG_W*DATA_W-1:0] ld_cnt  = '0;
  logic [FLAG_W*FLAG_W-1:0] ld_flag = '0;
  bit                       hold_done = 1'b0;

  task automatic m_insert(input logic [DATA_W-1:0] d, input logic [FLAG_W-1:0] f);
    int j;
    j = m_n;
    for (int k = 0; k < m_n; k++)
      if (m_cnt[k] > d) begin j = k; break; end
    for (int k = m_n; k > j; k--) begin
      m_cnt[k]  = m_cnt[k-1];
      m_flag[k] = m_flag[k-1];
    end
    m_cnt[j]  = d;
    m_flag[j] = f;
    m_n++;
  endtask

  task automatic m_pack();
    for (int e = 0; e < FLAG_W; e++) begin
      sorted_data[(FLAG_W-e)*DATA_W-1 -: DATA_W] = (e < m_n) ? m_cnt[e]  : '0;
      sorted_flag[(FLAG_W-e)*FLAG_W-1 -: FLAG_W] = (e < m_n) ? m_flag[e] : '0;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sort_done = 1'b0;
      m_timer   = 0;
    end else if (ld_seq != ld_seen) begin
      ld_seen = ld_seq;
      m_n = 0;
      for (int s = 0; s < ld_n; s++)
        m_insert(ld_cnt[(FLAG_W-s)*DATA_W-1 -: DATA_W], ld_flag[(FLAG_W-s)*FLAG_W-1 -: FLAG_W]);
      m_pack();
      sort_done = 1'b0;
      m_timer   = SORT_LAT;
    end else if (update_en) begin
      if (m_n >= 2) begin
        for (int k = 0; k < FLAG_W-2; k++) begin
          m_cnt[k]  = m_cnt[k+2];
          m_flag[k] = m_flag[k+2];
        end
        m_n -= 2;
        m_insert(update_data, update_flag);
      end
      m_pack();
      if (!hold_done) begin
        sort_done = 1'b0;
        m_timer   = SORT_LAT;
      end
    end else if (drop_seq != drop_seen) begin
      drop_seen = drop_seq;
      sort_done = 1'b0;
      m_timer   = SORT_LAT;
    end else if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) sort_done = 1'b1;
    end
  end

  task automatic load_onehot(input int n, input logic [FLAG_W*DATA_W-1:0] cnts);
    ld_n   = n;
    ld_cnt = cnts;
    for (int s = 0; s < FLAG_W; s++)
      ld_flag[(FLAG_W-s)*FLAG_W-1 -: FLAG_W] = FLAG_W'(1) << s;
    ld_seq++;
  endtask

  task automatic pulse_start(input logic [2:0] n);
    @(negedge clk);
    sym_num = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  function automatic bit outputs_zero();
    return {num, update_data, update_flag, update_en, code, code_len, busy, done, err} == '0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (!outputs_zero())
      $display("FAIL reset_outputs num=%0d data=%0d flag=%b en=%b code=%h len=%h busy=%b done=%b err=%b, want all 0",
               num, update_data, update_flag, update_en, code, code_len, busy, done, err);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_full_run(input bit stale);
    bit   ok;
    int   v0;
    upd_t e, o;
    exp_q.delete();
    obs_q.delete();
    v0 = viol;
    exp_q.push_back(mk(8'd3,  6'b001001, 3'd5));
    exp_q.push_back(mk(8'd6,  6'b011001, 3'd4));
    exp_q.push_back(mk(8'd9,  6'b100010, 3'd3));
    exp_q.push_back(mk(8'd12, 6'b011101, 3'd2));
    exp_q.push_back(mk(8'd21, 6'b111111, 3'd1));
    hold_done = stale;
    load_onehot(6, CNT6);
    pulse_start(3'd6);
    if (stale) begin
      for (int c = 0; c < 100 && obs_q.size() < 1; c++) @(negedge clk);
      repeat (8) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== 1 || busy !== 1'b1 || num !== 3'd5)
        $display("FAIL stale_hold updates=%0d busy=%b num=%0d, want updates=1 busy=1 num=5",
                 obs_q.size(), busy, num);
      else n_pass++;
      hold_done = 1'b0;
      drop_seq++;
    end
    wait_done(400, ok);
    n_checks++;
    if (!ok) $display("FAIL full_done_timeout done=%b, want 1", done);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL full_update_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e)
        $display("FAIL full_update got data=%0d flag=%b num=%0d want data=%0d flag=%b num=%0d",
                 o.data, o.flag, o.num, e.data, e.flag, e.num);
      else n_pass++;
    end
    n_checks++;
    if (code !== EXP_CODE6 || code_len !== EXP_LEN6)
      $display("FAIL full_codes code=%h len=%h want code=%h len=%h", code, code_len, EXP_CODE6, EXP_LEN6);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || viol !== v0)
      $display("FAIL full_status done=%b err=%b busy=%b back_to_back=%0d want 1 0 0 0",
               done, err, busy, viol - v0);
    else n_pass++;
  endtask

  task automatic test_two_symbol();
    bit   ok;
    upd_t o;
    obs_q.delete();
    load_onehot(2, {8'd7, 8'd9, 32'd0});
    pulse_start(3'd2);
    wait_done(200, ok);
    n_checks++;
    if (!ok || obs_q.size() !== 1)
      $display("FAIL two_updates done_seen=%b updates=%0d want 1 1", ok, obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o !== mk(8'd16, 6'b000011, 3'd1))
        $display("FAIL two_update got data=%0d flag=%b num=%0d want 16 000011 1", o.data, o.flag, o.num);
      else n_pass++;
    end
    n_checks++;
    if (code !== {5'd0, 5'd1, 20'd0} || code_len !== {3'd1, 3'd1, 12'd0} || num !== 3'd1 || err !== 1'b0)
      $display("FAIL two_codes code=%h len=%h num=%0d err=%b", code, code_len, num, err);
    else n_pass++;
  endtask

  task automatic test_invalid();
    logic [2:0] bad [2];
    bad[0] = 3'd1;
    bad[1] = 3'd7;
    for (int t = 0; t < 2; t++) begin
      obs_q.delete();
      pulse_start(bad[t]);
      n_checks++;
      if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || code !== '0)
        $display("FAIL invalid_%0d done=%b err=%b busy=%b code=%h want 1 1 0 0",
                 bad[t], done, err, busy, code);
      else n_pass++;
      repeat (4) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== 0) $display("FAIL invalid_%0d_updates got=%0d want 0", bad[t], obs_q.size());
      else n_pass++;
    end
  endtask

  task automatic test_flag_err();
    bit ok;
    obs_q.delete();
    ld_n    = 3;
    ld_cnt  = {8'd5, 8'd9, 8'd12, 24'd0};
    ld_flag = {6'b000001, 6'b000001, 6'b000100, 18'd0};
    ld_seq++;
    pulse_start(3'd3);
    wait_done(200, ok);
    n_checks++;
    if (!ok || err !== 1'b1 || obs_q.size() !== 0)
      $display("FAIL flag_overlap done_seen=%b err=%b updates=%0d want 1 1 0", ok, err, obs_q.size());
    else n_pass++;
  endtask

  task automatic test_stale_done();
    test_full_run(1'b1);
  endtask

  task automatic test_reset_mid_run();
    hold_done = 1'b0;
    obs_q.delete();
    load_onehot(6, CNT6);
    pulse_start(3'd6);
    for (int c = 0; c < 200 && obs_q.size() < 2; c++) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== 2) $display("FAIL midrun_reach_pass3 updates=%0d want 2", obs_q.size());
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!outputs_zero())
      $display("FAIL midrun_reset num=%0d data=%0d en=%b code=%h len=%h busy=%b done=%b err=%b, want all 0",
               num, update_data, update_en, code, code_len, busy, done, err);
    else n_pass++;
    reset = 1'b0;
    test_full_run(1'b0);
  endtask

  task automatic test_sum_overflow();
    bit   ok;
    upd_t o;
    obs_q.delete();
    load_onehot(2, {8'd200, 8'd100, 32'd0});
    pulse_start(3'd2);
    wait_done(200, ok);
    n_checks++;
    if (!ok || obs_q.size() !== 1)
      $display("FAIL ovf_updates done_seen=%b updates=%0d want 1 1", ok, obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o !== mk(OVF_EXP, 6'b000011, 3'd1))
        $display("FAIL ovf_update got data=%0d flag=%b num=%0d want %0d 000011 1",
                 o.data, o.flag, o.num, OVF_EXP);
      else n_pass++;
    end
    n_checks++;
    if (code !== {5'd1, 5'd0, 20'd0} || code_len !== {3'd1, 3'd1, 12'd0})
      $display("FAIL ovf_codes code=%h len=%h", code, code_len);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_run(1'b0);
    test_two_symbol();
    test_invalid();
    test_flag_err();
    test_stale_done();
    test_reset_mid_run();
    test_sum_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
